// File: rtl/weight_bn_pingpong_buf_if.sv
// Loader, swap and read signals of the ping-pong parameter buffer.
// master = DMA/datapath side, slave = buffer side.
interface weight_bn_pingpong_buf_if #(
  parameter int WEIGHT_WIDTH  = 8,
  parameter int W_ADDR_WIDTH  = 9,
  parameter int BN_WIDTH      = 16,
  parameter int BN_ADDR_WIDTH = 7
);
  logic                     load_start;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [BN_WIDTH-1:0]      ld_data;
  logic                     shadow_full;
  logic                     swap_req;
  logic                     swap_ack;
  logic                     active_bank;
  logic                     rd_en;
  logic [W_ADDR_WIDTH-1:0]  rd_w_addr;
  logic [BN_ADDR_WIDTH-1:0] rd_bn_addr;
  logic [WEIGHT_WIDTH-1:0]  rd_w_data;
  logic [BN_WIDTH-1:0]      rd_bn_data;
  logic                     rd_valid;

  modport master (
    output load_start, ld_valid, ld_data, swap_req, rd_en, rd_w_addr, rd_bn_addr,
    input  ld_ready, shadow_full, swap_ack, active_bank, rd_w_data, rd_bn_data, rd_valid
  );

  modport slave (
    input  load_start, ld_valid, ld_data, swap_req, rd_en, rd_w_addr, rd_bn_addr,
    output ld_ready, shadow_full, swap_ack, active_bank, rd_w_data, rd_bn_data, rd_valid
  );
endinterface

// File: rtl/weight_bn_pingpong_buf.sv
// Double-buffered weight/BN store: loader fills the shadow bank while reads hit the active bank.
// Reads return one cycle after rd_en; loader is throttled by ld_ready, held low outside LOAD_W/LOAD_BN.
module weight_bn_pingpong_buf #(
  parameter int WEIGHT_WIDTH  = 8,
  parameter int W_ADDR_WIDTH  = 9,
  parameter int W_DEPTH       = 512,
  parameter int BN_WIDTH      = 16,
  parameter int BN_ADDR_WIDTH = 7,
  parameter int BN_DEPTH      = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  weight_bn_pingpong_buf_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_BN, FULL} state_t;

  localparam logic [W_ADDR_WIDTH-1:0]  W_LAST  = W_ADDR_WIDTH'(W_DEPTH - 1);
  localparam logic [BN_ADDR_WIDTH-1:0] BN_LAST = BN_ADDR_WIDTH'(BN_DEPTH - 1);

  state_t                   state;
  logic [W_ADDR_WIDTH-1:0]  w_cnt;
  logic [BN_ADDR_WIDTH-1:0] bn_cnt;
  logic                     active_bank_q;
  logic                     ld_ready_q;
  logic                     shadow_full_q;
  logic                     swap_ack_q;
  logic                     rd_valid_q;
  logic [WEIGHT_WIDTH-1:0]  rd_w_data_q;
  logic [BN_WIDTH-1:0]      rd_bn_data_q;
  logic                     accept;
  logic                     shadow_bank;

  logic [WEIGHT_WIDTH-1:0] w_mem  [2][W_DEPTH];
  logic [BN_WIDTH-1:0]     bn_mem [2][BN_DEPTH];

  assign accept      = bus.ld_valid && ld_ready_q;
  assign shadow_bank = ~active_bank_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      w_cnt         <= '0;
      bn_cnt        <= '0;
      active_bank_q <= 1'b0;
      ld_ready_q    <= 1'b0;
      shadow_full_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          // The ack cycle is the first IDLE cycle after a swap; a start there is dropped.
          if (bus.load_start && !swap_ack_q) begin
            state      <= LOAD_W;
            w_cnt      <= '0;
            bn_cnt     <= '0;
            ld_ready_q <= 1'b1;
          end
        end
        LOAD_W: begin
          if (accept) begin
            if (w_cnt == W_LAST) begin
              state <= LOAD_BN;
              w_cnt <= '0;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        LOAD_BN: begin
          if (accept) begin
            if (bn_cnt == BN_LAST) begin
              state         <= FULL;
              bn_cnt        <= '0;
              ld_ready_q    <= 1'b0;
              shadow_full_q <= 1'b1;
            end else begin
              bn_cnt <= bn_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.swap_req) begin
            state         <= IDLE;
            active_bank_q <= ~active_bank_q;
            shadow_full_q <= 1'b0;
            swap_ack_q    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bank storage carries no reset; only the shadow bank is ever written.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      if (state == LOAD_W) begin
        w_mem[shadow_bank][w_cnt] <= bus.ld_data[WEIGHT_WIDTH-1:0];
      end else if (state == LOAD_BN) begin
        bn_mem[shadow_bank][bn_cnt] <= bus.ld_data;
      end
    end
  end

  // Uses the pre-edge active bank, so a read issued with a granted swap sees old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q   <= 1'b0;
      rd_w_data_q  <= '0;
      rd_bn_data_q <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_w_data_q  <= w_mem[active_bank_q][bus.rd_w_addr];
        rd_bn_data_q <= bn_mem[active_bank_q][bus.rd_bn_addr];
      end
    end
  end

  assign bus.ld_ready    = ld_ready_q;
  assign bus.shadow_full = shadow_full_q;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.active_bank = active_bank_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_w_data   = rd_w_data_q;
  assign bus.rd_bn_data  = rd_bn_data_q;

endmodule
